regfile_32x64: RTL
==================

# regfile_32x64

32-entry × 64-bit ARM integer register file: the write side of the operand-select path.
- A 5-to-32 write decoder steers one 64-bit writeback result into exactly one register.
- Two independent 32-to-1 read selectors feed the decode/register-read stage of the 5-stage pipeline.
- X31 is hardwired to zero.
- An optional compile-time write-through bypass resolves same-cycle write/read hazards without forwarding logic downstream.

## Interface
Parameters:
- DATA_W, 64, register width in bits.
- NREG, 32, number of architectural registers; register NREG-1 is the zero register.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- reset  input  1  Synchronous, active-high. Sampled on the rising edge of clk.
- RegWrite  input  1  Write enable for the current cycle.
- WriteRegister  input  5  Destination register index.
- WriteData  input  64  Data to write.
- ReadRegister1  input  5  Read port A index.
- ReadRegister2  input  5  Read port B index.
- ReadData1  output  64  Read port A data, combinational from index and state.
- ReadData2  output  64  Read port B data, combinational from index and state.

## Operation
- Storage: 31 writable 64-bit registers, X0–X30. X31 has no storage.
- Write decode: WriteRegister is decoded one-hot into 32 enables. Each enable is ANDed with RegWrite; bit 31 is forced to 0.
- A register captures WriteData only when its enable is 1. All other registers hold their value.
- Read: each port is a 32:1 selection of DATA_W bits indexed by its ReadRegister. Index 31 always returns 64'h0.
- Both read ports are fully independent. Both may read the same index, including the index being written.
- Reset: on a rising edge with reset=1, X0–X30 clear to 0. Any write presented in that cycle is discarded; reset has priority over RegWrite.
- Outputs after reset: ReadData1 = ReadData2 = 64'h0 for every index until a write occurs.
- The block raises no errors. Writes to X31 are silently dropped.

## Timing
- Write latency: 1 cycle. Data presented with RegWrite=1 at edge N is visible on the read ports from just after edge N.
- Read latency: 0 cycles, combinational. ReadData settles within the same cycle as an index change.
- Same-cycle write/read of the same index, bypass disabled: the read returns the old value until edge N. The pipeline handles this hazard externally.
- Same-cycle write/read of the same index, bypass enabled: see Configuration.
- Back-to-back writes to the same register on consecutive edges: the last write wins. No write is lost.
- Reset deasserted at edge N: the first write is accepted at edge N+1.
- Reset reasserted mid-sequence: all registers return to 0 on that edge, regardless of RegWrite.
- No X or Z may propagate to ReadData after the first reset edge.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: for each read port, when RegWrite=1, reset=0, WriteRegister≠31 and ReadRegisterK==WriteRegister, ReadDataK = WriteData in the same cycle (combinational write-through).
- Defined, X31: read of X31 still returns 0.
- Defined, reset=1: bypass is suppressed; reads return stored state.
- Undefined: no bypass path exists. Reads always reflect stored state only.
- Storage and write behaviour are identical in both builds.

## Test plan
- Reset then read all 32 indices on both ports -> every ReadData = 64'h0.
- Write X5 = 64'hDEADBEEF_CAFEF00D at edge 1. Read ports A=5, B=6 in cycle 2 -> A = 64'hDEADBEEF_CAFEF00D, B = 0.
- RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF, then read 31 on both ports -> 64'h0. No other register changes.
- Write X10 = 64'h1111 at edge 1, then in the next cycle present X10 = 64'h2222 while reading 10 before the edge:
  - Without REGFILE_BYPASS_EN -> 64'h1111.
  - With REGFILE_BYPASS_EN -> 64'h2222.
  - After the edge, both builds -> 64'h2222.
- RegWrite=0 with WriteRegister=3, WriteData=64'hABCD -> X3 stays 0.
- Fill X0–X30 with value i·64'h0101_0101_0101_0101, then assert reset together with a write of X7 = 64'h77 -> all reads 0 after the edge, including X7.

Source files
------------

// File: rtl/regfile_32x64_if.sv
// regfile_32x64_if
// Write and read-port bundle of the 32 x 64 integer register file.
// The master side (decode/writeback stage) drives the write port and
// both read indices; the slave side (the register file) returns read data.
interface regfile_32x64_if #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 5
);

  logic              RegWrite;
  logic [IDX_W-1:0]  WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [IDX_W-1:0]  ReadRegister1;
  logic [IDX_W-1:0]  ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2
  );

endinterface

// File: rtl/regfile_32x64.sv
// regfile_32x64
// 32-entry x 64-bit ARM integer register file with one write port and two
// independent combinational read ports. X31 is the zero register: it has no
// storage, writes to it are dropped and reads of it return zero.
// Optional build macro REGFILE_BYPASS_EN adds a combinational write-through
// so a read of the register being written this cycle returns WriteData.
module regfile_32x64 #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input logic              clk,
  input logic              reset,
  regfile_32x64_if.slave   rf
);

  localparam int IDX_W = $clog2(NREG);

  // Only X0..X(NREG-2) hold state; the zero register is synthesised as a
  // constant on the read side.
  logic [DATA_W-1:0] regs_q    [0:NREG-2];
  logic [DATA_W-1:0] regs_d    [0:NREG-2];
  logic [NREG-2:0]   wr_en;
  logic [DATA_W-1:0] read_view [0:NREG-1];

  // Write decoder: one-hot enable per writable register, qualified by
  // RegWrite. The zero register's enable is permanently 0, so it is simply
  // not generated.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NREG - 1; i++) begin
      wr_en[i] = rf.RegWrite && (rf.WriteRegister == IDX_W'(i));
    end
  end

  // Next-state for every register: reset clears, otherwise the enabled
  // register captures WriteData and the rest hold.
  always_comb begin
    for (int i = 0; i < NREG - 1; i++) begin
      regs_d[i] = regs_q[i];
      if (reset) begin
        regs_d[i] = '0;
      end else if (wr_en[i]) begin
        regs_d[i] = rf.WriteData;
      end
    end
  end

  // Register storage; reset is synchronous and handled in regs_d.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG - 1; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Full 32-entry read view so each read port is a plain 32:1 select with
  // the top entry tied to zero.
  always_comb begin
    for (int i = 0; i < NREG - 1; i++) begin
      read_view[i] = regs_q[i];
    end
    read_view[NREG-1] = '0;
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [IDX_W-1:0] ZERO_REG = IDX_W'(NREG - 1);

  logic bypass_ok;

  // A pending write can be forwarded only when it will actually land:
  // write enabled, not in reset and not aimed at the zero register.
  always_comb begin
    bypass_ok = rf.RegWrite && !reset && (rf.WriteRegister != ZERO_REG);
  end

  // Read port A with write-through of the in-flight write.
  always_comb begin
    rf.ReadData1 = read_view[rf.ReadRegister1];
    if (bypass_ok && (rf.ReadRegister1 == rf.WriteRegister)) begin
      rf.ReadData1 = rf.WriteData;
    end
  end

  // Read port B with write-through of the in-flight write.
  always_comb begin
    rf.ReadData2 = read_view[rf.ReadRegister2];
    if (bypass_ok && (rf.ReadRegister2 == rf.WriteRegister)) begin
      rf.ReadData2 = rf.WriteData;
    end
  end
`else
  // Read port A returns stored state only; same-cycle hazards are resolved
  // by the pipeline.
  always_comb begin
    rf.ReadData1 = read_view[rf.ReadRegister1];
  end

  // Read port B returns stored state only.
  always_comb begin
    rf.ReadData2 = read_view[rf.ReadRegister2];
  end
`endif

endmodule
